// File: rtl/uart_receiver.sv
// Purpose: 8N1 UART receive stage, 16x oversampled, with a host-facing byte register, ready flag and error status.
// Latency: the byte is loaded 154 clk edges after the first edge that samples the start bit's falling edge.
// Backpressure: none on the line; an unread byte is overwritten by the next frame and overrun is flagged.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int MID_SAMPLE = 7
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 rxd,
    input  logic                 rdn,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 r_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 s1_q, rxd_s_q;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 r_ready_q, r_ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 load;
    logic                 read;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            s1_q    <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            s1_q    <= rxd;
            rxd_s_q <= s1_q;
        end
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            bidx_q      <= 3'd0;
            sh_q        <= '0;
            d_out_q     <= '0;
            r_ready_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            sh_q        <= sh_d;
            d_out_q     <= d_out_d;
            r_ready_q   <= r_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: frame sequencing, bit sampling and host register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        sh_d        = sh_q;
        load        = 1'b0;
        read        = !rdn && r_ready_q;
        d_out_d     = d_out_q;
        r_ready_d   = r_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = 4'd0;
                end
            end
            S_START: begin
                if (cnt_q != 4'(MID_SAMPLE)) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (!rxd_s_q) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd0;
                    bidx_d  = 3'd0;
                end else begin
                    // Line went back high before mid-start: treat as a glitch.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != 4'd15) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    sh_d   = {rxd_s_q, sh_q[DATA_BITS-1:1]};
                    cnt_d  = 4'd0;
                    bidx_d = bidx_q + 3'd1;
                    if (bidx_q == 3'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != 4'd15) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    load    = 1'b1;
                    cnt_d   = 4'd0;
                    // A low stop bit may be a break; hold off start detection until the line idles.
                    state_d = rxd_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load beats a coincident read; a coincident read still counts as consuming the old byte.
        if (load) begin
            d_out_d     = sh_q;
            r_ready_d   = 1'b1;
            frame_err_d = ~rxd_s_q;
            if (read) begin
                overrun_d = 1'b0;
            end else if (r_ready_q) begin
                overrun_d = 1'b1;
            end
        end else if (read) begin
            r_ready_d   = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    // Output decode: everything visible to the host comes straight from registers.
    always_comb begin
        busy      = (state_q != S_IDLE);
        d_out     = d_out_q;
        r_ready   = r_ready_q;
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames with expected host-register results,
// followed by hand-written sequences for reset, glitch, break and mid-frame reset.
module tb_uart_receiver;

    logic       clk;
    logic       clrn;
    logic       rxd;
    logic       rdn;
    logic [7:0] d_out;
    logic       r_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests;
    int fails;

    uart_receiver #(.DATA_BITS(8), .MID_SAMPLE(7)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .rxd       (rxd),
        .rdn       (rdn),
        .d_out     (d_out),
        .r_ready   (r_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        int         rd_edge;     // edge index (from E0) with rdn low, -1 for none
        logic       read_after;  // pulse a read once the frame is done
        logic [7:0] e_dout;
        logic       e_ferr;
        logic       e_ovr;
        int         e_lat;       // expected first edge with r_ready high, -1 to skip
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one 160-edge frame; n is the edge index relative to E0.
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int rd_edge,
                              input int rst_edge, output int ready_edge);
        int idx;
        ready_edge = -1;
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            idx = n / 16;
            if (idx == 0)      rxd = 1'b0;
            else if (idx <= 8) rxd = b[idx-1];
            else               rxd = stopb;
            rdn  = (n == rd_edge)  ? 1'b0 : 1'b1;
            clrn = (n == rst_edge) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (r_ready && ready_edge < 0) ready_edge = n;
        end
        @(negedge clk);
        rdn  = 1'b1;
        clrn = 1'b1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic read_pulse();
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic saw_busy;
        logic busy_low_ok;

        tests = 0;
        fails = 0;

        tbl[0] = '{8'hA5, 1'b1, -1,  1'b1, 8'hA5, 1'b0, 1'b0, 154};
        tbl[1] = '{8'h11, 1'b1, -1,  1'b0, 8'h11, 1'b0, 1'b0, 154};
        tbl[2] = '{8'h22, 1'b1, -1,  1'b1, 8'h22, 1'b0, 1'b1, -1};
        tbl[3] = '{8'h11, 1'b1, -1,  1'b0, 8'h11, 1'b0, 1'b0, 154};
        tbl[4] = '{8'h22, 1'b1, 154, 1'b1, 8'h22, 1'b0, 1'b0, -1};
        tbl[5] = '{8'h81, 1'b1, -1,  1'b1, 8'h81, 1'b0, 1'b0, 154};

        // Reset held for 3 cycles with the line toggling.
        clrn = 1'b0;
        rdn  = 1'b1;
        rxd  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rxd = ~rxd;
        end
        @(negedge clk);
        chk("reset d_out", 32'(d_out), 32'h00);
        chk("reset r_ready", 32'(r_ready), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        clrn = 1'b1;
        rxd  = 1'b1;
        idle(5);

        // Table of frames: clean bytes, overrun, read-on-load-edge.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].stopb, tbl[i].rd_edge, -1, lat);
            idle(4);
            if (tbl[i].e_lat >= 0) chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].e_lat));
            chk($sformatf("v%0d d_out", i), 32'(d_out), 32'(tbl[i].e_dout));
            chk($sformatf("v%0d r_ready", i), 32'(r_ready), 32'h1);
            chk($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(tbl[i].e_ferr));
            chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'h0);
            if (tbl[i].read_after) begin
                read_pulse();
                chk($sformatf("v%0d read r_ready", i), 32'(r_ready), 32'h0);
                chk($sformatf("v%0d read overrun", i), 32'(overrun), 32'h0);
                chk($sformatf("v%0d read d_out", i), 32'(d_out), 32'(tbl[i].e_dout));
            end
        end

        // Start glitch: 5 cycles low must be rejected.
        saw_busy = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            rxd = (n < 5) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        chk("glitch busy pulsed", 32'(saw_busy), 32'h1);
        chk("glitch busy idle", 32'(busy), 32'h0);
        chk("glitch r_ready", 32'(r_ready), 32'h0);
        send_frame(8'h3C, 1'b1, -1, -1, lat);
        idle(4);
        chk("post-glitch latency", 32'(lat), 32'd154);
        chk("post-glitch d_out", 32'(d_out), 32'h3C);
        read_pulse();

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, -1, -1, lat);
        chk("ferr latency", 32'(lat), 32'd154);
        busy_low_ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            rxd = 1'b0;
            if (!busy) busy_low_ok = 1'b0;
        end
        chk("break busy held", 32'(busy_low_ok), 32'h1);
        chk("ferr d_out", 32'(d_out), 32'h55);
        chk("ferr frame_err", 32'(frame_err), 32'h1);
        chk("ferr r_ready", 32'(r_ready), 32'h1);
        idle(6);
        chk("break released busy", 32'(busy), 32'h0);
        idle(200);
        chk("no spurious byte overrun", 32'(overrun), 32'h0);
        chk("no spurious byte d_out", 32'(d_out), 32'h55);
        read_pulse();
        chk("ferr cleared by read", 32'(frame_err), 32'h0);

        // Reset for one cycle at E80 of a frame; remaining bits are all high.
        send_frame(8'hF0, 1'b1, -1, 80, lat);
        idle(4);
        chk("midreset d_out", 32'(d_out), 32'h00);
        chk("midreset r_ready", 32'(r_ready), 32'h0);
        chk("midreset frame_err", 32'(frame_err), 32'h0);
        chk("midreset overrun", 32'(overrun), 32'h0);
        chk("midreset busy", 32'(busy), 32'h0);
        send_frame(8'hF0, 1'b1, -1, -1, lat);
        idle(4);
        chk("post-reset latency", 32'(lat), 32'd154);
        chk("post-reset d_out", 32'(d_out), 32'hF0);
        chk("post-reset r_ready", 32'(r_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
